// File: rtl/rename_rat_pkg.sv
// Core-wide configuration constants and the shared rename/commit bundle types.
// core_config holds sizes; core_types derives PRF index and bundle structs from them.
package core_config;
    localparam int RENAME_WIDTH = 2;
    localparam int COMMIT_WIDTH = 2;
    localparam int ARCH_REG     = 32;
    localparam int PHYREG       = 64;
    localparam int PRF_W        = $clog2(PHYREG);
    localparam int AREG_W       = 5;
endpackage

package core_types;
    import core_config::*;

    typedef logic [PRF_W-1:0]  prf_idx_t;
    typedef logic [AREG_W-1:0] areg_t;

    typedef struct packed {
        logic  valid;
        logic  we;
        areg_t rd;
        areg_t rj;
        areg_t rk;
    } rename_req_t;

    typedef struct packed {
        prf_idx_t prj;
        prf_idx_t prk;
        prf_idx_t prd;
        prf_idx_t old_prd;
    } rename_rsp_t;

    typedef struct packed {
        logic     valid;
        logic     we;
        areg_t    rd;
        prf_idx_t prd;
        prf_idx_t old_prd;
    } commit_info_t;
endpackage

// File: rtl/rat_bypass.sv
// Intra-group dependency resolver: for each lane, finds the youngest older lane
// whose destination matches a source (or the lane's own rd, for old_prd).
module rat_bypass
    import core_types::*;
#(
    parameter int W  = 2,
    parameter int LW = 1
) (
    input  logic [W-1:0]         has_dest_i,
    input  areg_t [W-1:0]        rd_i,
    input  areg_t [W-1:0]        rj_i,
    input  areg_t [W-1:0]        rk_i,
    output logic [W-1:0]         rj_hit_o,
    output logic [W-1:0]         rk_hit_o,
    output logic [W-1:0]         rd_hit_o,
    output logic [W-1:0][LW-1:0] rj_sel_o,
    output logic [W-1:0][LW-1:0] rk_sel_o,
    output logic [W-1:0][LW-1:0] rd_sel_o
);

    always_comb begin
        rj_hit_o = '0;
        rk_hit_o = '0;
        rd_hit_o = '0;
        rj_sel_o = '0;
        rk_sel_o = '0;
        rd_sel_o = '0;
        // ascending scan so the youngest matching older lane overwrites earlier hits
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                if (j < i && has_dest_i[j]) begin
                    if (rd_i[j] == rj_i[i]) begin
                        rj_hit_o[i] = 1'b1;
                        rj_sel_o[i] = LW'(j);
                    end
                    if (rd_i[j] == rk_i[i]) begin
                        rk_hit_o[i] = 1'b1;
                        rk_sel_o[i] = LW'(j);
                    end
                    if (rd_i[j] == rd_i[i]) begin
                        rd_hit_o[i] = 1'b1;
                        rd_sel_o[i] = LW'(j);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/rename_rat.sv
// Speculative + committed register alias table for the rename stage.
// Optional RAT_STATS_EN adds saturating rename/flush counters.
module rename_rat
    import core_types::*;
#(
    parameter int RENAME_WIDTH = core_config::RENAME_WIDTH,
    parameter int COMMIT_WIDTH = core_config::COMMIT_WIDTH,
    parameter int ARCH_REG     = core_config::ARCH_REG,
    parameter int PHYREG       = core_config::PHYREG,
    localparam int PW          = $clog2(PHYREG)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [RENAME_WIDTH-1:0]             rename_valid_i,
    output logic                                rename_ready_o,
    input  logic [RENAME_WIDTH-1:0][4:0]        rename_rd_i,
    input  logic [RENAME_WIDTH-1:0][4:0]        rename_rj_i,
    input  logic [RENAME_WIDTH-1:0][4:0]        rename_rk_i,
    input  logic [RENAME_WIDTH-1:0]             rename_we_i,
    input  logic [RENAME_WIDTH-1:0][PW-1:0]     free_prf_i,
    output logic [RENAME_WIDTH-1:0]             out_valid_o,
    input  logic                                out_ready_i,
    output logic [RENAME_WIDTH-1:0][PW-1:0]     out_prj_o,
    output logic [RENAME_WIDTH-1:0][PW-1:0]     out_prk_o,
    output logic [RENAME_WIDTH-1:0][PW-1:0]     out_prd_o,
    output logic [RENAME_WIDTH-1:0][PW-1:0]     out_old_prd_o,
    output logic [RENAME_WIDTH-1:0]             alloc_o,
    input  logic [COMMIT_WIDTH-1:0]             commit_valid_i,
    input  logic [COMMIT_WIDTH-1:0]             commit_we_i,
    input  logic [COMMIT_WIDTH-1:0][4:0]        commit_rd_i,
    input  logic [COMMIT_WIDTH-1:0][PW-1:0]     commit_prd_i,
    input  logic [COMMIT_WIDTH-1:0][PW-1:0]     commit_old_prd_i,
    output logic [COMMIT_WIDTH-1:0]             release_o,
    output logic [COMMIT_WIDTH-1:0][PW-1:0]     release_prf_o,
    input  logic                                flush_i
`ifdef RAT_STATS_EN
    ,
    output logic [31:0]                         stat_renamed_o,
    output logic [15:0]                         stat_flush_o
`endif
);

    localparam int LW = (RENAME_WIDTH > 1) ? $clog2(RENAME_WIDTH) : 1;

    rename_req_t  [RENAME_WIDTH-1:0] req;
    rename_rsp_t  [RENAME_WIDTH-1:0] rsp;
    commit_info_t [COMMIT_WIDTH-1:0] cmt;
    logic  [RENAME_WIDTH-1:0]        has_dest;
    areg_t [RENAME_WIDTH-1:0]        rd_v, rj_v, rk_v;
    logic  [RENAME_WIDTH-1:0]        rj_hit, rk_hit, rd_hit;
    logic  [RENAME_WIDTH-1:0][LW-1:0] rj_sel, rk_sel, rd_sel;
    logic                            fire;

    logic [PW-1:0] spec_q [ARCH_REG];
    logic [PW-1:0] spec_d [ARCH_REG];
    logic [PW-1:0] arch_q [ARCH_REG];
    logic [PW-1:0] arch_d [ARCH_REG];

    logic        [RENAME_WIDTH-1:0] out_valid_q, out_valid_d;
    rename_rsp_t [RENAME_WIDTH-1:0] out_rsp_q, out_rsp_d;
    logic [COMMIT_WIDTH-1:0]         release_q, release_d;
    logic [COMMIT_WIDTH-1:0][PW-1:0] release_prf_q, release_prf_d;

    always_comb begin
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            req[i] = '{valid: rename_valid_i[i], we: rename_we_i[i],
                       rd: rename_rd_i[i], rj: rename_rj_i[i], rk: rename_rk_i[i]};
            has_dest[i] = req[i].valid && req[i].we && (req[i].rd != '0);
            rd_v[i] = req[i].rd;
            rj_v[i] = req[i].rj;
            rk_v[i] = req[i].rk;
        end
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            cmt[i] = '{valid: commit_valid_i[i], we: commit_we_i[i], rd: commit_rd_i[i],
                       prd: commit_prd_i[i], old_prd: commit_old_prd_i[i]};
        end
    end

    rat_bypass #(.W(RENAME_WIDTH), .LW(LW)) u_bypass (
        .has_dest_i (has_dest),
        .rd_i       (rd_v),
        .rj_i       (rj_v),
        .rk_i       (rk_v),
        .rj_hit_o   (rj_hit),
        .rk_hit_o   (rk_hit),
        .rd_hit_o   (rd_hit),
        .rj_sel_o   (rj_sel),
        .rk_sel_o   (rk_sel),
        .rd_sel_o   (rd_sel)
    );

    assign rename_ready_o = !flush_i && (!(|out_valid_q) || out_ready_i);
    assign fire           = rename_ready_o && (|rename_valid_i);
    assign alloc_o        = fire ? has_dest : '0;

    always_comb begin
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            rsp[i].prj = (req[i].rj == '0) ? '0 :
                         rj_hit[i] ? free_prf_i[rj_sel[i]] : spec_q[req[i].rj];
            rsp[i].prk = (req[i].rk == '0) ? '0 :
                         rk_hit[i] ? free_prf_i[rk_sel[i]] : spec_q[req[i].rk];
            rsp[i].prd = has_dest[i] ? free_prf_i[i] : '0;
            rsp[i].old_prd = !has_dest[i] ? '0 :
                             rd_hit[i] ? free_prf_i[rd_sel[i]] : spec_q[req[i].rd];
        end
    end

    always_comb begin
        arch_d = arch_q;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            release_d[i]     = cmt[i].valid && cmt[i].we && (cmt[i].rd != '0);
            release_prf_d[i] = cmt[i].old_prd;
            if (release_d[i]) arch_d[cmt[i].rd] = cmt[i].prd;
        end
        // flush restores from the committed map including this cycle's commits
        spec_d = spec_q;
        if (flush_i) begin
            spec_d = arch_d;
        end else if (fire) begin
            for (int i = 0; i < RENAME_WIDTH; i++) begin
                if (has_dest[i]) spec_d[req[i].rd] = free_prf_i[i];
            end
        end
        out_valid_d = out_valid_q;
        out_rsp_d   = out_rsp_q;
        if (flush_i) begin
            out_valid_d = '0;
        end else if (fire) begin
            out_valid_d = rename_valid_i;
            out_rsp_d   = rsp;
        end else if (out_ready_i) begin
            out_valid_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < ARCH_REG; k++) begin
                spec_q[k] <= PW'(k);
                arch_q[k] <= PW'(k);
            end
            out_valid_q   <= '0;
            out_rsp_q     <= '0;
            release_q     <= '0;
            release_prf_q <= '0;
        end else begin
            spec_q        <= spec_d;
            arch_q        <= arch_d;
            out_valid_q   <= out_valid_d;
            out_rsp_q     <= out_rsp_d;
            release_q     <= release_d;
            release_prf_q <= release_prf_d;
        end
    end

    always_comb begin
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            out_prj_o[i]     = out_rsp_q[i].prj;
            out_prk_o[i]     = out_rsp_q[i].prk;
            out_prd_o[i]     = out_rsp_q[i].prd;
            out_old_prd_o[i] = out_rsp_q[i].old_prd;
        end
    end

    assign out_valid_o   = out_valid_q;
    assign release_o     = release_q;
    assign release_prf_o = release_prf_q;

`ifdef RAT_STATS_EN
    localparam int PCW = $clog2(RENAME_WIDTH + 1);

    logic [31:0]    stat_ren_q, stat_ren_d;
    logic [15:0]    stat_fl_q, stat_fl_d;
    logic [PCW-1:0] pop;
    logic [32:0]    ren_sum;

    always_comb begin
        pop = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) pop = pop + PCW'(alloc_o[i]);
        ren_sum    = {1'b0, stat_ren_q} + 33'(pop);
        stat_ren_d = ren_sum[32] ? '1 : ren_sum[31:0];
        stat_fl_d  = (flush_i && stat_fl_q != '1) ? stat_fl_q + 16'd1 : stat_fl_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ren_q <= '0;
            stat_fl_q  <= '0;
        end else begin
            stat_ren_q <= stat_ren_d;
            stat_fl_q  <= stat_fl_d;
        end
    end

    assign stat_renamed_o = stat_ren_q;
    assign stat_flush_o   = stat_fl_q;
`endif

endmodule

// File: tb/tb_rename_rat.sv
// Directed self-checking bench for rename_rat.
module tb_rename_rat;

    logic            clk;
    logic            rst;
    logic [1:0]      rename_valid_i;
    logic            rename_ready_o;
    logic [1:0][4:0] rename_rd_i;
    logic [1:0][4:0] rename_rj_i;
    logic [1:0][4:0] rename_rk_i;
    logic [1:0]      rename_we_i;
    logic [1:0][5:0] free_prf_i;
    logic [1:0]      out_valid_o;
    logic            out_ready_i;
    logic [1:0][5:0] out_prj_o;
    logic [1:0][5:0] out_prk_o;
    logic [1:0][5:0] out_prd_o;
    logic [1:0][5:0] out_old_prd_o;
    logic [1:0]      alloc_o;
    logic [1:0]      commit_valid_i;
    logic [1:0]      commit_we_i;
    logic [1:0][4:0] commit_rd_i;
    logic [1:0][5:0] commit_prd_i;
    logic [1:0][5:0] commit_old_prd_i;
    logic [1:0]      release_o;
    logic [1:0][5:0] release_prf_o;
    logic            flush_i;
`ifdef RAT_STATS_EN
    logic [31:0]     stat_renamed_o;
    logic [15:0]     stat_flush_o;
`endif

    int checks = 0;
    int errors = 0;

    rename_rat dut (
        .clk              (clk),
        .rst              (rst),
        .rename_valid_i   (rename_valid_i),
        .rename_ready_o   (rename_ready_o),
        .rename_rd_i      (rename_rd_i),
        .rename_rj_i      (rename_rj_i),
        .rename_rk_i      (rename_rk_i),
        .rename_we_i      (rename_we_i),
        .free_prf_i       (free_prf_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_prj_o        (out_prj_o),
        .out_prk_o        (out_prk_o),
        .out_prd_o        (out_prd_o),
        .out_old_prd_o    (out_old_prd_o),
        .alloc_o          (alloc_o),
        .commit_valid_i   (commit_valid_i),
        .commit_we_i      (commit_we_i),
        .commit_rd_i      (commit_rd_i),
        .commit_prd_i     (commit_prd_i),
        .commit_old_prd_i (commit_old_prd_i),
        .release_o        (release_o),
        .release_prf_o    (release_prf_o),
        .flush_i          (flush_i)
`ifdef RAT_STATS_EN
        ,
        .stat_renamed_o   (stat_renamed_o),
        .stat_flush_o     (stat_flush_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear();
        rename_valid_i   = '0;
        rename_we_i      = '0;
        rename_rd_i      = '0;
        rename_rj_i      = '0;
        rename_rk_i      = '0;
        free_prf_i       = '0;
        commit_valid_i   = '0;
        commit_we_i      = '0;
        commit_rd_i      = '0;
        commit_prd_i     = '0;
        commit_old_prd_i = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (out_valid_o !== 2'b00) begin errors++; $display("FAIL reset_out_valid: got %b expected 00", out_valid_o); end
        checks++; if (release_o !== 2'b00) begin errors++; $display("FAIL reset_release: got %b expected 00", release_o); end
        checks++; if (out_prd_o !== '0) begin errors++; $display("FAIL reset_prd: got %h expected 0", out_prd_o); end
        checks++; if (out_prj_o !== '0) begin errors++; $display("FAIL reset_prj: got %h expected 0", out_prj_o); end
        checks++; if (out_old_prd_o !== '0) begin errors++; $display("FAIL reset_old_prd: got %h expected 0", out_old_prd_o); end
        checks++; if (release_prf_o !== '0) begin errors++; $display("FAIL reset_release_prf: got %h expected 0", release_prf_o); end
        checks++; if (rename_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", rename_ready_o); end
    endtask

    task automatic test_basic();
        clear();
        rename_valid_i = 2'b01; rename_we_i = 2'b01;
        rename_rd_i[0] = 5'd5; rename_rj_i[0] = 5'd5; free_prf_i[0] = 6'd40;
        #1;
        checks++; if (alloc_o !== 2'b01) begin errors++; $display("FAIL basic_alloc: got %b expected 01", alloc_o); end
        step();
        checks++; if (out_valid_o !== 2'b01) begin errors++; $display("FAIL basic_valid: got %b expected 01", out_valid_o); end
        checks++; if (out_prj_o[0] !== 6'd5) begin errors++; $display("FAIL basic_prj: got %0d expected 5", out_prj_o[0]); end
        checks++; if (out_prd_o[0] !== 6'd40) begin errors++; $display("FAIL basic_prd: got %0d expected 40", out_prd_o[0]); end
        checks++; if (out_old_prd_o[0] !== 6'd5) begin errors++; $display("FAIL basic_old: got %0d expected 5", out_old_prd_o[0]); end
        clear();
        rename_valid_i = 2'b01; rename_rj_i[0] = 5'd5; rename_rk_i[0] = 5'd5;
        step();
        checks++; if (out_prj_o[0] !== 6'd40) begin errors++; $display("FAIL basic_prj2: got %0d expected 40", out_prj_o[0]); end
        checks++; if (out_prk_o[0] !== 6'd40) begin errors++; $display("FAIL basic_prk2: got %0d expected 40", out_prk_o[0]); end
        checks++; if (out_prd_o[0] !== 6'd0) begin errors++; $display("FAIL basic_nodest_prd: got %0d expected 0", out_prd_o[0]); end
        clear();
        step();
        checks++; if (out_valid_o !== 2'b00) begin errors++; $display("FAIL basic_drain: got %b expected 00", out_valid_o); end
    endtask

    task automatic test_group();
        clear();
        rename_valid_i = 2'b11; rename_we_i = 2'b11;
        rename_rd_i[0] = 5'd3; rename_rj_i[0] = 5'd1; free_prf_i[0] = 6'd41;
        rename_rd_i[1] = 5'd3; rename_rj_i[1] = 5'd3; rename_rk_i[1] = 5'd5; free_prf_i[1] = 6'd42;
        #1;
        checks++; if (alloc_o !== 2'b11) begin errors++; $display("FAIL group_alloc: got %b expected 11", alloc_o); end
        step();
        checks++; if (out_prj_o[0] !== 6'd1) begin errors++; $display("FAIL group_prj0: got %0d expected 1", out_prj_o[0]); end
        checks++; if (out_old_prd_o[0] !== 6'd3) begin errors++; $display("FAIL group_old0: got %0d expected 3", out_old_prd_o[0]); end
        checks++; if (out_prj_o[1] !== 6'd41) begin errors++; $display("FAIL group_prj1: got %0d expected 41", out_prj_o[1]); end
        checks++; if (out_prk_o[1] !== 6'd40) begin errors++; $display("FAIL group_prk1: got %0d expected 40", out_prk_o[1]); end
        checks++; if (out_old_prd_o[1] !== 6'd41) begin errors++; $display("FAIL group_old1: got %0d expected 41", out_old_prd_o[1]); end
        checks++; if (out_prd_o[1] !== 6'd42) begin errors++; $display("FAIL group_prd1: got %0d expected 42", out_prd_o[1]); end
        clear();
        rename_valid_i = 2'b01; rename_rj_i[0] = 5'd3;
        step();
        checks++; if (out_prj_o[0] !== 6'd42) begin errors++; $display("FAIL group_map3: got %0d expected 42", out_prj_o[0]); end
        clear();
        step();
    endtask

    task automatic test_rd_zero();
        clear();
        rename_valid_i = 2'b01; rename_we_i = 2'b01;
        rename_rd_i[0] = 5'd0; rename_rj_i[0] = 5'd0; rename_rk_i[0] = 5'd3; free_prf_i[0] = 6'd50;
        #1;
        checks++; if (alloc_o !== 2'b00) begin errors++; $display("FAIL rd0_alloc: got %b expected 00", alloc_o); end
        step();
        checks++; if (out_valid_o !== 2'b01) begin errors++; $display("FAIL rd0_valid: got %b expected 01", out_valid_o); end
        checks++; if (out_prd_o[0] !== 6'd0) begin errors++; $display("FAIL rd0_prd: got %0d expected 0", out_prd_o[0]); end
        checks++; if (out_old_prd_o[0] !== 6'd0) begin errors++; $display("FAIL rd0_old: got %0d expected 0", out_old_prd_o[0]); end
        checks++; if (out_prj_o[0] !== 6'd0) begin errors++; $display("FAIL rd0_prj: got %0d expected 0", out_prj_o[0]); end
        checks++; if (out_prk_o[0] !== 6'd42) begin errors++; $display("FAIL rd0_prk: got %0d expected 42", out_prk_o[0]); end
        clear();
        step();
    endtask

    task automatic test_backpressure();
        clear();
        rename_valid_i = 2'b01; rename_we_i = 2'b01;
        rename_rd_i[0] = 5'd6; rename_rj_i[0] = 5'd6; free_prf_i[0] = 6'd43;
        step();
        checks++; if (out_prd_o[0] !== 6'd43) begin errors++; $display("FAIL bp_first_prd: got %0d expected 43", out_prd_o[0]); end
        out_ready_i = 1'b0;
        rename_rd_i[0] = 5'd8; free_prf_i[0] = 6'd47;
        #1;
        checks++; if (rename_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b expected 0", rename_ready_o); end
        checks++; if (alloc_o !== 2'b00) begin errors++; $display("FAIL bp_alloc: got %b expected 00", alloc_o); end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (out_valid_o !== 2'b01) begin errors++; $display("FAIL bp_hold_valid: cycle %0d got %b expected 01", c, out_valid_o); end
            checks++; if (out_prd_o[0] !== 6'd43) begin errors++; $display("FAIL bp_hold_prd: cycle %0d got %0d expected 43", c, out_prd_o[0]); end
            checks++; if (out_old_prd_o[0] !== 6'd6) begin errors++; $display("FAIL bp_hold_old: cycle %0d got %0d expected 6", c, out_old_prd_o[0]); end
            checks++; if (alloc_o !== 2'b00) begin errors++; $display("FAIL bp_hold_alloc: cycle %0d got %b expected 00", c, alloc_o); end
        end
        out_ready_i = 1'b1;
        #1;
        checks++; if (alloc_o !== 2'b01) begin errors++; $display("FAIL bp_release_alloc: got %b expected 01", alloc_o); end
        step();
        checks++; if (out_prd_o[0] !== 6'd47) begin errors++; $display("FAIL bp_next_prd: got %0d expected 47", out_prd_o[0]); end
        checks++; if (out_old_prd_o[0] !== 6'd8) begin errors++; $display("FAIL bp_next_old: got %0d expected 8", out_old_prd_o[0]); end
        clear();
        step();
    endtask

    task automatic test_commit_flush();
        clear();
        commit_valid_i = 2'b01; commit_we_i = 2'b01;
        commit_rd_i[0] = 5'd7; commit_prd_i[0] = 6'd44; commit_old_prd_i[0] = 6'd7;
        flush_i = 1'b1;
        rename_valid_i = 2'b01; rename_we_i = 2'b01; rename_rd_i[0] = 5'd10; free_prf_i[0] = 6'd48;
        #1;
        checks++; if (rename_ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", rename_ready_o); end
        checks++; if (alloc_o !== 2'b00) begin errors++; $display("FAIL flush_alloc: got %b expected 00", alloc_o); end
        step();
        checks++; if (release_o !== 2'b01) begin errors++; $display("FAIL flush_release: got %b expected 01", release_o); end
        checks++; if (release_prf_o[0] !== 6'd7) begin errors++; $display("FAIL flush_release_prf: got %0d expected 7", release_prf_o[0]); end
        checks++; if (out_valid_o !== 2'b00) begin errors++; $display("FAIL flush_out_valid: got %b expected 00", out_valid_o); end
        clear();
        flush_i = 1'b0;
        rename_valid_i = 2'b11;
        rename_rj_i[0] = 5'd7; rename_rk_i[0] = 5'd5;
        rename_rj_i[1] = 5'd3; rename_rk_i[1] = 5'd10;
        step();
        checks++; if (out_prj_o[0] !== 6'd44) begin errors++; $display("FAIL flush_map7: got %0d expected 44", out_prj_o[0]); end
        checks++; if (out_prk_o[0] !== 6'd5) begin errors++; $display("FAIL flush_map5: got %0d expected 5", out_prk_o[0]); end
        checks++; if (out_prj_o[1] !== 6'd3) begin errors++; $display("FAIL flush_map3: got %0d expected 3", out_prj_o[1]); end
        checks++; if (out_prk_o[1] !== 6'd10) begin errors++; $display("FAIL flush_map10: got %0d expected 10", out_prk_o[1]); end
        checks++; if (release_o !== 2'b00) begin errors++; $display("FAIL flush_release_clear: got %b expected 00", release_o); end
        clear();
        step();
    endtask

    task automatic test_dual_commit();
        clear();
        commit_valid_i = 2'b11; commit_we_i = 2'b11;
        commit_rd_i[0] = 5'd9; commit_prd_i[0] = 6'd45; commit_old_prd_i[0] = 6'd9;
        commit_rd_i[1] = 5'd9; commit_prd_i[1] = 6'd46; commit_old_prd_i[1] = 6'd45;
        step();
        checks++; if (release_o !== 2'b11) begin errors++; $display("FAIL dual_release: got %b expected 11", release_o); end
        checks++; if (release_prf_o[0] !== 6'd9) begin errors++; $display("FAIL dual_prf0: got %0d expected 9", release_prf_o[0]); end
        checks++; if (release_prf_o[1] !== 6'd45) begin errors++; $display("FAIL dual_prf1: got %0d expected 45", release_prf_o[1]); end
        clear();
        rename_valid_i = 2'b01; rename_rj_i[0] = 5'd9;
        step();
        checks++; if (out_prj_o[0] !== 6'd9) begin errors++; $display("FAIL dual_spec_untouched: got %0d expected 9", out_prj_o[0]); end
        clear();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        rename_valid_i = 2'b01; rename_rj_i[0] = 5'd9;
        step();
        checks++; if (out_prj_o[0] !== 6'd46) begin errors++; $display("FAIL dual_arch9: got %0d expected 46", out_prj_o[0]); end
        clear();
        step();
    endtask

    task automatic test_same_reg();
        clear();
        rename_valid_i = 2'b01; rename_we_i = 2'b01; rename_rd_i[0] = 5'd12; free_prf_i[0] = 6'd49;
        commit_valid_i = 2'b01; commit_we_i = 2'b01;
        commit_rd_i[0] = 5'd12; commit_prd_i[0] = 6'd50; commit_old_prd_i[0] = 6'd12;
        step();
        checks++; if (out_old_prd_o[0] !== 6'd12) begin errors++; $display("FAIL same_old: got %0d expected 12", out_old_prd_o[0]); end
        checks++; if (release_prf_o[0] !== 6'd12) begin errors++; $display("FAIL same_release_prf: got %0d expected 12", release_prf_o[0]); end
        clear();
        rename_valid_i = 2'b01; rename_rj_i[0] = 5'd12;
        step();
        checks++; if (out_prj_o[0] !== 6'd49) begin errors++; $display("FAIL same_spec12: got %0d expected 49", out_prj_o[0]); end
        clear();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        rename_valid_i = 2'b01; rename_rj_i[0] = 5'd12;
        step();
        checks++; if (out_prj_o[0] !== 6'd50) begin errors++; $display("FAIL same_arch12: got %0d expected 50", out_prj_o[0]); end
        clear();
        step();
    endtask

    task automatic test_async_reset();
        clear();
        rename_valid_i = 2'b01; rename_we_i = 2'b01; rename_rd_i[0] = 5'd14; free_prf_i[0] = 6'd51;
        commit_valid_i = 2'b01; commit_we_i = 2'b01;
        commit_rd_i[0] = 5'd13; commit_prd_i[0] = 6'd52; commit_old_prd_i[0] = 6'd13;
        step();
        checks++; if (release_o !== 2'b01) begin errors++; $display("FAIL arst_pre_release: got %b expected 01", release_o); end
        clear();
        #2 rst = 1'b1;
        #1;
        checks++; if (release_o !== 2'b00) begin errors++; $display("FAIL arst_release: got %b expected 00", release_o); end
        checks++; if (out_valid_o !== 2'b00) begin errors++; $display("FAIL arst_valid: got %b expected 00", out_valid_o); end
        checks++; if (out_prd_o[0] !== 6'd0) begin errors++; $display("FAIL arst_prd: got %0d expected 0", out_prd_o[0]); end
        #1 rst = 1'b0;
        rename_valid_i = 2'b01; rename_rj_i[0] = 5'd14; rename_rk_i[0] = 5'd9;
        step();
        checks++; if (out_prj_o[0] !== 6'd14) begin errors++; $display("FAIL arst_map14: got %0d expected 14", out_prj_o[0]); end
        checks++; if (out_prk_o[0] !== 6'd9) begin errors++; $display("FAIL arst_map9: got %0d expected 9", out_prk_o[0]); end
        clear();
        step();
    endtask

    initial begin
        rst = 1'b1;
        out_ready_i = 1'b1;
        flush_i = 1'b0;
        clear();
        #12;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        step();
        test_basic();
        test_group();
        test_rd_zero();
        test_backpressure();
        test_commit_flush();
        test_dual_commit();
        test_same_reg();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rename_rat.md
# rename_rat

Speculative register alias table (RAT) for the rename stage. It sits directly downstream of the physical-register free list and consumes the PRF indices the free list hands out. It maps each renamed instruction's architectural sources and destination to physical registers and keeps a committed map for flush recovery. On commit it returns each displaced physical register to the free list.

## Interface
Parameters:
- RENAME_WIDTH, 2, instructions renamed per cycle
- COMMIT_WIDTH, 2, instructions committed per cycle
- ARCH_REG, 32, architectural registers (r0 hardwired zero)
- PHYREG, 64, physical registers; PRF index width is $clog2(PHYREG)

Ports (per-lane buses are packed arrays indexed by lane):
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- rename_valid_i  in  RENAME_WIDTH  lane holds an instruction
- rename_ready_o  out  1  group accepted this cycle
- rename_rd_i / rename_rj_i / rename_rk_i  in  RENAME_WIDTH×5  arch dest / sources
- rename_we_i  in  RENAME_WIDTH  lane writes rd
- free_prf_i  in  RENAME_WIDTH×log2(PHYREG)  new PRF per lane from free list
- out_valid_o  out  RENAME_WIDTH  registered lane valid
- out_ready_i  in  1  downstream (dispatch) accepts
- out_prj_o / out_prk_o / out_prd_o / out_old_prd_o  out  RENAME_WIDTH×log2(PHYREG)  renamed operands, displaced PRF
- alloc_o  out  RENAME_WIDTH  lane consumed its free_prf_i (rename request to free list)
- commit_valid_i  in  COMMIT_WIDTH  lane commits
- commit_we_i / commit_rd_i / commit_prd_i / commit_old_prd_i  in  per-lane  committed dest info
- release_o  out  COMMIT_WIDTH  registered: PRF returned to free list
- release_prf_o  out  COMMIT_WIDTH×log2(PHYREG)
- flush_i  in  1  restore speculative map from committed map

## Operation
- Group accepted (fire) when rename_ready_o && any rename_valid_i; rename_ready_o = !flush_i && (!out_valid_o-any || out_ready_i).
- Lane has-dest = valid && we && rd≠0. alloc_o[i] = fire && has-dest[i] (combinational; the free list advances on it).
- Source lookup: prj = spec_map[rj]; arch 0 always reads PRF 0. Intra-group bypass: a source in lane i matching the rd of lane j<i with has-dest takes lane j's free_prf_i; the youngest such j wins.
- old_prd: spec_map[rd], bypassed the same way from older lanes; 0 when not has-dest. out_prd_o = free_prf_i if has-dest, else 0.
- Spec map write on fire: per has-dest lane, spec_map[rd] <= free_prf_i; the younger lane wins on the same rd.
- Commit: arch_map[rd] <= commit_prd_i for each valid lane with we and rd≠0, younger lane wins. release_o[i] <= same condition; release_prf_o <= commit_old_prd_i.
- Flush: spec_map <= arch_map including same-cycle commits. out_valid_o cleared. Rename inputs are ignored and alloc_o=0. Commits and releases proceed normally.
- Output register holds its value while out_valid_o && !out_ready_i.

## Timing
- Reset: spec_map[i]=arch_map[i]=i for all i; out_valid_o=0, release_o=0, all PRF outputs 0. Free list owns PRFs ARCH_REG..PHYREG-1.
- Rename latency is 1 cycle, fire→out_valid_o. Full throughput with out_ready_i held high.
- Commit→release_o is 1 cycle. A commit is visible in arch_map the next cycle.
- A flush in cycle N means renames in N+1 see the restored map.
- Rename and commit to the same arch reg in one cycle each update their own map independently.
- Reset asserted mid-operation clears everything asynchronously, including pending releases.

## Configuration
- RAT_STATS_EN defined: adds outputs stat_renamed_o[31:0], incremented by the popcount of alloc_o, and stat_flush_o[15:0], incremented per flush. Both saturate and reset to 0.
- RAT_STATS_EN undefined: these ports and counters do not exist. Functional behaviour is otherwise identical.

## Structure
- Shared package core_config: RENAME_WIDTH, COMMIT_WIDTH, ARCH_REG, PHYREG.
- Shared package core_types: typedef prf_idx_t, rename_req_t {valid, we, rd, rj, rk}, rename_rsp_t {prj, prk, prd, old_prd}, commit_info_t {valid, we, rd, prd, old_prd}.
- One sub-module: rat_bypass. A combinational intra-group dependency resolver producing per-lane source and old_prd selects.

## Test plan
- Reset, rename lane0 rd=5 with rj=5 and free_prf=40 -> next cycle prj=5, prd=40, old_prd=5; then rj=5 reads 40.
- Group lane0 rd=3 with prf 41, lane1 rj=3 rd=3 with prf 42 -> lane1 prj=41, old_prd=41. spec_map[3]=42.
- rd=0 with we=1 -> alloc_o=0, prd=0, old_prd=0; rj=0 -> prj=0.
- out_ready_i=0 for 3 cycles with valid output -> outputs stable, rename_ready_o=0, alloc_o=0.
- Commit rd=7 with prd=44 and old=7 plus flush in the same cycle -> release_o with prf 7 next cycle. spec_map[7]=44; any other speculative map entries revert to arch values.
- Both commit lanes rd=9 (prd 45 old 9, then prd 46 old 45) -> arch_map[9]=46; releases 9 and 45 next cycle.
